// File: rtl/emulib_uart_phy_if.sv
// emulib_uart_phy_if: byte-stream side of the UART PHY.
// master = UART register/FIFO model, slave = PHY.
interface emulib_uart_phy_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, rx_frame_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, rx_frame_err
  );
endinterface

// File: rtl/emulib_uart_phy.sv
// emulib_uart_phy: fixed-divisor full-duplex 8N1 serial PHY.
// Ports: clk, rst_n, bus (tx byte in / rx byte out), txd out, rxd in.
module emulib_uart_phy #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  emulib_uart_phy_if.slave bus,
  output logic             txd,
  input  logic             rxd
);
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
  } rx_st_t;

  // ---------------- TX ----------------
  tx_st_t        tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          txd_n;
  logic          tx_hs;
  logic          tx_exp;
  logic          tx_ready;

  assign tx_exp = (tx_cnt == '0);
  assign tx_hs  = bus.tx_valid && tx_ready;
  assign bus.tx_ready = tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_st <= T_IDLE;
    else        tx_st <= tx_st_n;
  end

  always_comb begin
    tx_st_n = tx_st;
    unique case (tx_st)
      T_IDLE:  if (tx_hs) tx_st_n = T_START;
      T_START: if (tx_exp) tx_st_n = T_DATA;
      T_DATA:  if (tx_exp && tx_bit == 3'd7)
                 tx_st_n = T_STOP;
      T_STOP:  if (tx_exp) tx_st_n = T_IDLE;
      default: tx_st_n = T_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (tx_st == T_IDLE);
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    txd_n    = 1'b1;
    if (tx_hs) begin
      tx_cnt_n = FULL;
      tx_bit_n = '0;
      tx_sh_n  = bus.tx_data;
    end else if (tx_st != T_IDLE) begin
      tx_cnt_n = tx_exp ? FULL : tx_cnt - CW'(1);
      if (tx_st == T_DATA && tx_exp) begin
        tx_bit_n = tx_bit + 3'd1;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
      end
    end
    // txd is registered: drive the level of
    // the state being entered on this edge.
    unique case (tx_st_n)
      T_START: txd_n = 1'b0;
      T_DATA:  txd_n = tx_sh_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      txd    <= 1'b1;
    end else begin
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
      txd    <= txd_n;
    end
  end

  // ---------------- RX ----------------
  rx_st_t        rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic [7:0]    rx_data, rx_data_n;
  logic          rx_valid, rx_valid_n;
  logic          rx_err, rx_err_n;
  logic          rx_s1, rx_s2;
  logic          rxs;
  logic          rx_exp;

  assign rxs    = rx_s2;
  assign rx_exp = (rx_cnt == '0);

  assign bus.rx_valid     = rx_valid;
  assign bus.rx_data      = rx_data;
  assign bus.rx_frame_err = rx_err;

  // Idle-high synchronizer so reset never
  // looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_st <= R_IDLE;
    else        rx_st <= rx_st_n;
  end

  always_comb begin
    rx_st_n = rx_st;
    unique case (rx_st)
      R_IDLE:  if (!rxs) rx_st_n = R_START;
      R_START: if (rx_exp)
                 rx_st_n = rxs ? R_IDLE : R_DATA;
      R_DATA:  if (rx_exp && rx_bit == 3'd7)
                 rx_st_n = R_STOP;
      R_STOP:  if (rx_exp)
                 rx_st_n = rxs ? R_IDLE : R_BREAK;
      R_BREAK: if (rxs) rx_st_n = R_IDLE;
      default: rx_st_n = R_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        if (!rxs) rx_cnt_n = HALF;
      end
      R_START, R_DATA, R_STOP: begin
        rx_cnt_n = rx_exp ? FULL : rx_cnt - CW'(1);
        if (rx_st == R_START) rx_bit_n = '0;
        if (rx_exp && rx_st == R_DATA) begin
          rx_sh_n  = {rxs, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
        end
        if (rx_exp && rx_st == R_STOP) begin
          rx_valid_n = rxs;
          rx_err_n   = !rxs;
          if (rxs) rx_data_n = rx_sh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rx_err   <= rx_err_n;
    end
  end
endmodule

// File: tb/tb_emulib_uart_phy.sv
// tb_emulib_uart_phy: behavioural-model bench for the UART PHY.
// Two instances: CLK_DIV=16 (loopback capable) and CLK_DIV=5.
module tb_emulib_uart_phy;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  emulib_uart_phy_if bus16 ();
  emulib_uart_phy_if bus5 ();

  logic       txd16, txd5, rxd16, rxd5;
  logic       tv   [2];
  logic [7:0] td   [2];
  logic       rdrv [2];
  logic       loop16;

  assign bus16.tx_valid = tv[0];
  assign bus16.tx_data  = td[0];
  assign bus5.tx_valid  = tv[1];
  assign bus5.tx_data   = td[1];
  assign rxd16 = loop16 ? txd16 : rdrv[0];
  assign rxd5  = rdrv[1];

  emulib_uart_phy #(.CLK_DIV(16)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16),
    .txd(txd16), .rxd(rxd16)
  );

  emulib_uart_phy #(.CLK_DIV(5)) u5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5),
    .txd(txd5), .rxd(rxd5)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void chk(input string nm,
      input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // Model state and per-cycle logs
  logic       hist [2][32768];
  logic       txw  [2][32768];
  logic       rdw  [2][32768];
  int         th   [2];
  logic [7:0] tbyte[2];
  int         hs_n [2];
  int         hs_c [2];
  int         ph   [2];
  int         t0   [2];
  logic       ev   [2];
  logic       ee   [2];
  logic [7:0] ed   [2];
  int         vcnt [2];
  int         ecnt [2];
  int         vcyc [2][64];
  logic [7:0] vdat [2][64];

  task automatic step(input int id, input int n,
      input logic rst, input logic txd_a,
      input logic rdy_a, input logic v_a,
      input logic e_a, input logic [7:0] d_a,
      input logic line, input logic tv_a,
      input logic [7:0] td_a);
    int d;
    int h;
    int k;
    logic rs;
    logic xtxd;
    logic xrdy;
    logic [7:0] b;
    d = (id == 0) ? 16 : 5;
    h = d / 2;
    txw[id][n] = txd_a;
    rdw[id][n] = rdy_a;
    if (v_a === 1'b1) begin
      if (vcnt[id] < 64) begin
        vcyc[id][vcnt[id]] = n;
        vdat[id][vcnt[id]] = d_a;
      end
      vcnt[id]++;
    end
    if (e_a === 1'b1) ecnt[id]++;
    if (!rst) begin
      chk("rst_txd", txd_a, 1);
      chk("rst_tx_ready", rdy_a, 1);
      chk("rst_rx_valid", v_a, 0);
      chk("rst_frame_err", e_a, 0);
      chk("rst_rx_data", d_a, 0);
      hist[id][n] = 1'b1;
      th[id] = -1;
      ph[id] = 0;
      ev[id] = 0;
      ee[id] = 0;
      ed[id] = 8'h00;
      return;
    end
    hist[id][n] = line;
    // TX: frame of 10 bit slots after the handshake
    xrdy = 1'b1;
    xtxd = 1'b1;
    if (th[id] >= 0) begin
      k = n - th[id];
      if (k >= 1 && k <= 10 * d) begin
        xrdy = 1'b0;
        if (k <= d) xtxd = 1'b0;
        else if (k <= 9 * d)
          xtxd = tbyte[id][(k - 1) / d - 1];
      end
    end
    chk("txd", txd_a, xtxd);
    chk("tx_ready", rdy_a, xrdy);
    if (tv_a && xrdy) begin
      th[id] = n;
      tbyte[id] = td_a;
      hs_n[id]++;
      hs_c[id] = n;
    end
    // RX: outputs decided by last cycle's sample
    chk("rx_valid", v_a, ev[id]);
    chk("rx_frame_err", e_a, ee[id]);
    chk("rx_data", d_a, ed[id]);
    ev[id] = 0;
    ee[id] = 0;
    rs = (n >= 2) ? hist[id][n-2] : 1'b1;
    case (ph[id])
      0: if (!rs) begin
        t0[id] = n;
        ph[id] = 1;
      end
      1: begin
        if (n == t0[id] + h) begin
          if (rs) ph[id] = 0;
        end else if (n == t0[id] + h + 9 * d) begin
          for (int i = 0; i < 8; i++)
            b[i] = hist[id][t0[id] + h + (i + 1) * d - 2];
          if (rs) begin
            ev[id] = 1;
            ed[id] = b;
            ph[id] = 0;
          end else begin
            ee[id] = 1;
            ph[id] = 2;
          end
        end
      end
      2: if (rs) ph[id] = 0;
      default: ph[id] = 0;
    endcase
  endtask

  always @(negedge clk) begin
    step(0, cyc, rst_n, txd16, bus16.tx_ready,
         bus16.rx_valid, bus16.rx_frame_err,
         bus16.rx_data, rxd16, tv[0], td[0]);
    step(1, cyc, rst_n, txd5, bus5.tx_ready,
         bus5.rx_valid, bus5.rx_frame_err,
         bus5.rx_data, rxd5, tv[1], td[1]);
    cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int id,
      input logic [7:0] b, input bit hold);
    int prev;
    logic ok;
    prev = hs_n[id];
    tv[id] = 1'b1;
    td[id] = b;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (hs_n[id] != prev) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_handshake", ok, 1);
    @(posedge clk);
    #1;
    if (!hold) tv[id] = 1'b0;
  endtask

  task automatic frame(input int id,
      input logic [7:0] b, input logic stp);
    int d;
    d = (id == 0) ? 16 : 5;
    rdrv[id] = 1'b0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      rdrv[id] = b[i];
      tick(d);
    end
    rdrv[id] = stp;
    tick(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int v0;
    int e0;
    logic [9:0] pat;
    logic [7:0] sb [4];
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b0;
      td[i] = 8'h00;
      rdrv[i] = 1'b1;
      th[i] = -1;
      ph[i] = 0;
      ev[i] = 0;
      ee[i] = 0;
      ed[i] = 8'h00;
      hs_n[i] = 0;
      hs_c[i] = 0;
      vcnt[i] = 0;
      ecnt[i] = 0;
    end
    loop16 = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("idle_txd16", txd16, 1);
    chk("idle_ready16", bus16.tx_ready, 1);
    chk("idle_rxdata16", bus16.rx_data, 8'h00);

    // TX waveform A5 (looped back)
    v0 = vcnt[0];
    send(0, 8'hA5, 0);
    h = hs_c[0];
    tick(200);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 10; j++)
      chk("wave_A5", txw[0][h + 1 + 16 * j + 8], pat[j]);
    chk("wave_start_first", txw[0][h + 1], 0);
    chk("wave_start_last", txw[0][h + 16], 0);
    chk("wave_stop_first", txw[0][h + 145], 1);
    chk("wave_stop_last", txw[0][h + 160], 1);
    chk("ready_low_160", rdw[0][h + 160], 0);
    chk("ready_high_161", rdw[0][h + 161], 1);
    chk("loop_A5_count", vcnt[0], v0 + 1);
    chk("loop_A5_cycle", vcyc[0][v0], h + 156);
    chk("loop_A5_data", vdat[0][v0], 8'hA5);

    // Reset in the middle of a TX frame
    send(0, 8'hA5, 0);
    h = hs_c[0];
    v0 = vcnt[0];
    while (cyc <= h + 50) begin
      @(negedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", txd16, 1);
    chk("async_rst_ready", bus16.tx_ready, 1);
    chk("async_rst_valid", bus16.rx_valid, 0);
    tick(3);
    rst_n = 1'b1;
    tick(200);
    chk("rst_no_valid", vcnt[0], v0);
    send(0, 8'h3C, 0);
    h = hs_c[0];
    tick(200);
    chk("after_rst_count", vcnt[0], v0 + 1);
    chk("after_rst_cycle", vcyc[0][v0], h + 156);
    chk("after_rst_data", vdat[0][v0], 8'h3C);

    // Back-to-back loopback stream
    sb[0] = 8'h00;
    sb[1] = 8'hFF;
    sb[2] = 8'h55;
    sb[3] = 8'h80;
    v0 = vcnt[0];
    h = 0;
    for (int j = 0; j < 4; j++) begin
      send(0, sb[j], j < 3);
      if (j == 0) h = hs_c[0];
    end
    tick(400);
    chk("stream_count", vcnt[0], v0 + 4);
    for (int j = 0; j < 4; j++) begin
      chk("stream_data", vdat[0][v0 + j], sb[j]);
      chk("stream_cycle", vcyc[0][v0 + j],
          h + 156 + j * 161);
    end

    // Glitch rejection
    loop16 = 1'b0;
    rdrv[0] = 1'b1;
    tick(20);
    v0 = vcnt[0];
    e0 = ecnt[0];
    rdrv[0] = 1'b0;
    tick(4);
    rdrv[0] = 1'b1;
    tick(40);
    chk("glitch_valid", vcnt[0], v0);
    chk("glitch_err", ecnt[0], e0);

    // Framing error then a clean frame
    frame(0, 8'h12, 1'b0);
    tick(100);
    rdrv[0] = 1'b1;
    tick(40);
    chk("ferr_count", ecnt[0], e0 + 1);
    chk("ferr_no_valid", vcnt[0], v0);
    chk("ferr_data_held", bus16.rx_data, 8'h80);
    frame(0, 8'h34, 1'b1);
    tick(40);
    chk("post_ferr_count", vcnt[0], v0 + 1);
    chk("post_ferr_data", vdat[0][v0], 8'h34);
    chk("post_ferr_rx_data", bus16.rx_data, 8'h34);

    // CLK_DIV=5 full duplex
    v0 = vcnt[1];
    fork
      frame(1, 8'hC3, 1'b1);
      begin
        tick(7);
        send(1, 8'h5A, 0);
      end
    join
    h = hs_c[1];
    tick(60);
    chk("div5_rx_count", vcnt[1], v0 + 1);
    chk("div5_rx_data", vdat[1][v0], 8'hC3);
    chk("div5_rx_held", bus5.rx_data, 8'hC3);
    pat = {1'b1, 8'h5A, 1'b0};
    for (int j = 0; j < 10; j++)
      chk("div5_wave_5A", txw[1][h + 1 + 5 * j + 2], pat[j]);
    chk("div5_ready_low", rdw[1][h + 50], 0);
    chk("div5_ready_high", rdw[1][h + 51], 1);

    // Randomized traffic, checked by the model
    loop16 = 1'b1;
    tick(5);
    fork
      begin : rnd_tx
        for (int i = 0; i < 12; i++) begin
          send(0, 8'($urandom), 1'($urandom_range(0, 1)));
          tick($urandom_range(0, 30));
        end
        tv[0] = 1'b0;
      end
      begin : rnd_rx
        int r;
        for (int i = 0; i < 25; i++) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            rdrv[1] = 1'b0;
            tick($urandom_range(1, 2));
            rdrv[1] = 1'b1;
          end else begin
            frame(1, 8'($urandom), r != 1);
            if (r == 1) tick($urandom_range(0, 20));
            rdrv[1] = 1'b1;
          end
          tick($urandom_range(0, 6));
        end
      end
    join
    tick(400);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
